// File: rtl/com_pkg.sv
// Shared types and constants for the NeoGeo COM link controller.
package com_pkg;

  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_STOP
  } txState_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rxState_t;

  // Status word bit positions as seen on the 68K read bus.
  localparam int BIT_RXRDY  = 15;
  localparam int BIT_TXFULL = 14;
  localparam int BIT_FERR   = 13;
  localparam int BIT_OVR    = 12;
  localparam int BIT_TOGGLE = 11;

  // 48 MHz / 48 = 1 Mbit/s.
  localparam int BAUD_DIV_DEFAULT = 48;

  // Bit timers count down from this value to zero, so one bit is div cycles.
  function automatic logic [11:0] baudReload(input int div);
    return 12'(div - 1);
  endfunction

endpackage

// File: rtl/com_uart_rx.sv
// Serial receiver: synchronizes the incoming line, detects start bits,
// samples each bit at its midpoint and reports complete or broken frames.
module com_uart_rx
  import com_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       CLK_48M,
  input  logic       nRESET,
  input  logic       enable,
  input  logic       rxIn,
  output logic [7:0] rxByte,
  output logic       rxValid,
  output logic       rxFerr
);

  localparam logic [11:0] RELOAD = baudReload(BAUD_DIV);
  localparam logic [11:0] HALF   = 12'(BAUD_DIV / 2 - 1);

  logic       sync1;
  logic       sync2;
  logic       rxLast;
  logic       rxFall;
  rxState_t   state;
  rxState_t   stateNext;
  logic [11:0] timer;
  logic [11:0] timerNext;
  logic [2:0] bitCnt;
  logic [2:0] bitCntNext;
  logic [7:0] shiftReg;
  logic [7:0] shiftNext;

  // Two-stage synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge CLK_48M) begin
    if (!nRESET) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      rxLast <= 1'b1;
    end else begin
      sync1  <= rxIn;
      sync2  <= sync1;
      rxLast <= sync2;
    end
  end

  assign rxFall = rxLast & ~sync2;

  // Receiver state, bit timer, bit counter and shift register.
  always_ff @(posedge CLK_48M) begin
    if (!nRESET) begin
      state    <= R_IDLE;
      timer    <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
    end else begin
      state    <= stateNext;
      timer    <= timerNext;
      bitCnt   <= bitCntNext;
      shiftReg <= shiftNext;
    end
  end

  // Next-state logic; completion pulses come straight from the stop-bit sample.
  always_comb begin
    stateNext  = state;
    timerNext  = timer;
    bitCntNext = bitCnt;
    shiftNext  = shiftReg;
    rxValid    = 1'b0;
    rxFerr     = 1'b0;
    case (state)
      R_IDLE: begin
        if (rxFall) begin
          stateNext = R_START;
          timerNext = HALF;
        end
      end
      R_START: begin
        if (timer == 12'd0) begin
          if (sync2) begin
            stateNext = R_IDLE;
          end else begin
            stateNext  = R_DATA;
            timerNext  = RELOAD;
            bitCntNext = 3'd0;
          end
        end else begin
          timerNext = timer - 12'd1;
        end
      end
      R_DATA: begin
        if (timer == 12'd0) begin
          shiftNext = {sync2, shiftReg[7:1]};
          timerNext = RELOAD;
          if (bitCnt == 3'd7) begin
            stateNext = R_STOP;
          end else begin
            bitCntNext = bitCnt + 3'd1;
          end
        end else begin
          timerNext = timer - 12'd1;
        end
      end
      R_STOP: begin
        if (timer == 12'd0) begin
          rxValid   = sync2;
          rxFerr    = ~sync2;
          stateNext = R_IDLE;
        end else begin
          timerNext = timer - 12'd1;
        end
      end
    endcase
    if (!enable) begin
      stateNext = R_IDLE;
      timerNext = '0;
      rxValid   = 1'b0;
      rxFerr    = 1'b0;
    end
  end

  assign rxByte = shiftReg;

endmodule

// File: rtl/com_link_ctrl.sv
// NeoGeo COM port controller: 68K port decode, status flags, transmit
// buffer and 8N1 serializer, with an idle-reply toggle when the link is off.
module com_link_ctrl
  import com_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic        CLK_48M,
  input  logic        nRESET,
  input  logic        nPORTOEL,
  input  logic        nPORTOEU,
  input  logic        nPORTWEL,
  input  logic [7:0]  M68K_DOUT,
  output logic [15:0] M68K_DIN,
  input  logic        LINK_EN,
  input  logic        LINK_RX,
  output logic        LINK_TX
);

  localparam logic [11:0] RELOAD = baudReload(BAUD_DIV);

  logic        welPrev;
  logic        oelPrev;
  logic        oeuPrev;
  logic        writeEvt;
  logic        oelEvt;
  logic        oeuEvt;

  logic        toggle;
  logic        rxRdy;
  logic        txFull;
  logic        ferr;
  logic        ovr;
  logic [7:0]  rxData;
  logic [7:0]  hold;

  txState_t    txState;
  txState_t    txStateNext;
  logic [11:0] txTimer;
  logic [11:0] txTimerNext;
  logic [2:0]  txBit;
  logic [2:0]  txBitNext;
  logic [7:0]  shiftReg;
  logic [7:0]  shiftNext;
  logic        txLoad;
  logic        txAccept;

  logic [7:0]  rxByte;
  logic        rxValid;
  logic        rxFerr;
  logic [7:0]  hiByte;

  com_uart_rx #(
    .BAUD_DIV(BAUD_DIV)
  ) uRx (
    .CLK_48M(CLK_48M),
    .nRESET (nRESET),
    .enable (LINK_EN),
    .rxIn   (LINK_RX),
    .rxByte (rxByte),
    .rxValid(rxValid),
    .rxFerr (rxFerr)
  );

  // Registered strobe copies; an event is the strobe returning high.
  always_ff @(posedge CLK_48M) begin
    if (!nRESET) begin
      welPrev <= 1'b1;
      oelPrev <= 1'b1;
      oeuPrev <= 1'b1;
    end else begin
      welPrev <= nPORTWEL;
      oelPrev <= nPORTOEL;
      oeuPrev <= nPORTOEU;
    end
  end

  assign writeEvt = ~welPrev & nPORTWEL;
  assign oelEvt   = ~oelPrev & nPORTOEL;
  assign oeuEvt   = ~oeuPrev & nPORTOEU;

  // A write is accepted if the buffer is empty or is being emptied this cycle.
  assign txAccept = LINK_EN & writeEvt & (~txFull | txLoad);

  // Idle-reply toggle flips on every write regardless of link state.
  always_ff @(posedge CLK_48M) begin
    if (!nRESET) begin
      toggle <= 1'b0;
    end else if (writeEvt) begin
      toggle <= ~toggle;
    end
  end

  // Transmit holding register and its full flag.
  always_ff @(posedge CLK_48M) begin
    if (!nRESET) begin
      hold   <= '0;
      txFull <= 1'b0;
    end else if (!LINK_EN) begin
      txFull <= 1'b0;
    end else if (txAccept) begin
      hold   <= M68K_DOUT;
      txFull <= 1'b1;
    end else if (txLoad) begin
      txFull <= 1'b0;
    end
  end

  // Error flags: sets take priority over the clearing high-byte read.
  always_ff @(posedge CLK_48M) begin
    if (!nRESET) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if ((LINK_EN & writeEvt & txFull & ~txLoad) | (rxValid & rxRdy)) begin
        ovr <= 1'b1;
      end else if (oeuEvt) begin
        ovr <= 1'b0;
      end
      if (rxFerr) begin
        ferr <= 1'b1;
      end else if (oeuEvt) begin
        ferr <= 1'b0;
      end
    end
  end

  // Receive register; a completing frame beats the clearing low-byte read.
  always_ff @(posedge CLK_48M) begin
    if (!nRESET) begin
      rxRdy  <= 1'b0;
      rxData <= '0;
    end else if (rxValid) begin
      rxRdy  <= 1'b1;
      rxData <= rxByte;
    end else if (oelEvt) begin
      rxRdy <= 1'b0;
    end
  end

  // Transmitter state, bit timer, bit counter and shift register.
  always_ff @(posedge CLK_48M) begin
    if (!nRESET) begin
      txState  <= T_IDLE;
      txTimer  <= '0;
      txBit    <= '0;
      shiftReg <= '0;
    end else begin
      txState  <= txStateNext;
      txTimer  <= txTimerNext;
      txBit    <= txBitNext;
      shiftReg <= shiftNext;
    end
  end

  // Transmit sequencing; stop can chain straight into the next start bit.
  always_comb begin
    txStateNext = txState;
    txTimerNext = txTimer;
    txBitNext   = txBit;
    shiftNext   = shiftReg;
    txLoad      = 1'b0;
    case (txState)
      T_IDLE: begin
        if (txFull) begin
          txLoad      = 1'b1;
          txStateNext = T_START;
          txTimerNext = RELOAD;
          shiftNext   = hold;
        end
      end
      T_START: begin
        if (txTimer == 12'd0) begin
          txStateNext = T_DATA;
          txTimerNext = RELOAD;
          txBitNext   = 3'd0;
        end else begin
          txTimerNext = txTimer - 12'd1;
        end
      end
      T_DATA: begin
        if (txTimer == 12'd0) begin
          shiftNext   = {1'b0, shiftReg[7:1]};
          txTimerNext = RELOAD;
          if (txBit == 3'd7) begin
            txStateNext = T_STOP;
          end else begin
            txBitNext = txBit + 3'd1;
          end
        end else begin
          txTimerNext = txTimer - 12'd1;
        end
      end
      T_STOP: begin
        if (txTimer == 12'd0) begin
          if (txFull) begin
            txLoad      = 1'b1;
            txStateNext = T_START;
            txTimerNext = RELOAD;
            shiftNext   = hold;
          end else begin
            txStateNext = T_IDLE;
          end
        end else begin
          txTimerNext = txTimer - 12'd1;
        end
      end
    endcase
    if (!LINK_EN) begin
      txStateNext = T_IDLE;
      txTimerNext = '0;
      txLoad      = 1'b0;
    end
  end

  // Line driver decoded from the current state so reset and disable act at once.
  always_comb begin
    LINK_TX = 1'b1;
    if (LINK_EN) begin
      case (txState)
        T_START: LINK_TX = 1'b0;
        T_DATA:  LINK_TX = shiftReg[0];
        default: LINK_TX = 1'b1;
      endcase
    end
  end

  // Status byte; link-dependent flags read zero while the link is off.
  always_comb begin
    hiByte                  = '0;
    hiByte[BIT_RXRDY - 8]   = rxRdy & LINK_EN;
    hiByte[BIT_TXFULL - 8]  = txFull & LINK_EN;
    hiByte[BIT_FERR - 8]    = ferr & LINK_EN;
    hiByte[BIT_OVR - 8]     = ovr;
    hiByte[BIT_TOGGLE - 8]  = toggle;
  end

  assign M68K_DIN[15:8] = nPORTOEU ? 8'bzzzz_zzzz : hiByte;
  assign M68K_DIN[7:0]  = nPORTOEL ? 8'bzzzz_zzzz : (LINK_EN ? rxData : 8'h00);

endmodule

// File: doc/com_link_ctrl.md
# com_link_ctrl

Sequences the NeoGeo COM port between the 68K and a two-cabinet serial link. 68K port writes are buffered and serialized out as 8N1 frames, and incoming frames are deserialized into a receive register. Status bits are presented on the port read path. When the link is disabled, the block degrades to the idle-reply behaviour: a toggle bit flips on each write, which keeps link-aware games running at normal speed. It sits on the 68K port decode alongside the cartridge port logic and drives the 68K data-in bus only while a port read strobe is low.

## Interface
Parameters:
- BAUD_DIV, default 48: CLK_48M cycles per serial bit (1 Mbit/s); legal range 8..4095.

Ports:
- CLK_48M  in  1  system clock; all logic on rising edge.
- nRESET  in  1  synchronous, active-low reset.
- nPORTOEL  in  1  port read strobe, low byte, active low.
- nPORTOEU  in  1  port read strobe, high byte, active low.
- nPORTWEL  in  1  port write strobe, low byte, active low.
- M68K_DOUT  in  8  68K data bits 7:0 during writes.
- M68K_DIN  out  16  read data; high-Z per byte while the matching strobe is high.
- LINK_EN  in  1  1 = serial link active; 0 = idle-reply mode.
- LINK_RX  in  1  asynchronous serial input, idle high.
- LINK_TX  out  1  serial output, idle high.

## Operation
- Strobe edges:
  - Registered copies of nPORTWEL, nPORTOEL and nPORTOEU; each resets to 1.
  - An event is a rising edge: prev=0, cur=1.
- Read map:
  - High byte = {RXRDY, TXFULL, FERR, OVR, TOGGLE, 3'b000}, bits 15..8.
  - Low byte = RXDATA.
- Write event:
  - TOGGLE flips on every write event.
  - If LINK_EN=1 and TXFULL=0: HOLD <= M68K_DOUT and TXFULL <= 1.
  - If LINK_EN=1 and TXFULL=1: data is dropped and OVR <= 1.
- nPORTOEL event: RXRDY <= 0.
- nPORTOEU event: OVR <= 0 and FERR <= 0.
- TX FSM, states T_IDLE, T_START, T_DATA, T_STOP:
  - T_IDLE with TXFULL=1: SHIFT <= HOLD, TXFULL <= 0, go to T_START.
  - T_START drives 0. T_DATA drives 8 bits, LSB first. T_STOP drives 1.
  - Each state lasts BAUD_DIV cycles per bit.
  - T_STOP returns to T_IDLE. It may chain directly into T_START if TXFULL=1.
- RX path, sub-module com_uart_rx, states R_IDLE, R_START, R_DATA, R_STOP:
  - LINK_RX passes through a 2-FF synchronizer.
  - A falling edge in R_IDLE enters R_START.
  - At BAUD_DIV/2 the line is re-sampled. If it is high, the start was a glitch: return to R_IDLE with no flag change.
  - Data bits are sampled every BAUD_DIV cycles at mid-bit, LSB first.
  - R_STOP samples the stop bit. If it is 0: FERR <= 1 and the byte is discarded.
  - If it is 1: RXDATA <= byte and RXRDY <= 1. If RXRDY was already 1, OVR <= 1 as well (the new byte overwrites).
  - The FSM then returns to R_IDLE.
- LINK_EN=0:
  - LINK_TX=1; both FSMs are held in idle; HOLD is not loaded.
  - RXRDY, TXFULL and FERR read 0; the low byte reads 0x00.
  - TOGGLE still operates.
- Simultaneous events:
  - nPORTOEL event in the same cycle as RX completion: the set wins, so RXRDY=1 with new data.
  - Write event in the same cycle as the T_IDLE→T_START transfer: the transfer takes the old HOLD, the new data loads HOLD, and TXFULL stays 1.
  - nPORTOEU event in the same cycle as an OVR set: the set wins.
- LINK_EN falling mid-frame: the TX frame is aborted immediately, LINK_TX=1, TXFULL is cleared and the RX FSM goes to R_IDLE.

## Timing
- Reset values:
  - LINK_TX=1; M68K_DIN high-Z (strobes are high).
  - TOGGLE=0, RXRDY=0, TXFULL=0, FERR=0, OVR=0.
  - RXDATA=0x00, HOLD=0x00; FSMs idle; bit timers 0.
  - Reset asserted mid-frame takes effect on the next edge. LINK_TX returns to 1 on that same edge.
- Read path is combinational from the registers to M68K_DIN, gated by the strobes: zero-cycle latency.
- Write event cycle N: HOLD and TOGGLE are updated at edge N.
  - The TX FSM sees TXFULL at N+1; LINK_TX falls after edge N+1.
  - The full frame takes 10×BAUD_DIV cycles; LINK_TX=1 by N+1+10×BAUD_DIV.
- RX timing:
  - Synchronizer latency is 2 cycles.
  - RXRDY rises 2 + 9.5×BAUD_DIV (±1) cycles after the LINK_RX start-bit falling edge.
- Bit timer: a 12-bit down-counter reloaded with BAUD_DIV-1. It wraps only via reload and never underflows.

## Structure
- Package com_pkg holds:
  - TX and RX state enums.
  - Status bit positions: RXRDY=15, TXFULL=14, FERR=13, OVR=12, TOGGLE=11.
  - The BAUD_DIV default.
- Sub-module com_uart_rx contains the synchronizer, RX FSM and bit timer. Its outputs are a byte, a valid pulse and a frame-error pulse.
- The top level holds the strobe edge detection, flags, HOLD, the TX FSM and the read mux.

## Test plan
- Reset, then read both bytes → M68K_DIN=0x0000 and LINK_TX=1.
- LINK_EN=0, three write pulses → TOGGLE=1, 0, 1 (upper byte 0x08, 0x00, 0x08); LINK_TX stays 1.
- LINK_EN=1, write 0xA5 → LINK_TX frame is 0,1,0,1,0,0,1,0,1,1 at BAUD_DIV spacing, and TXFULL clears at the start bit.
- Write 0x11, 0x22, 0x33 back-to-back during the first frame → 0x11 and 0x22 are transmitted, 0x33 is dropped, and the upper-byte read shows OVR=1, then 0 on the next read.
- LINK_RX loopback from LINK_TX carrying 0x3C → RXRDY=1 with low byte 0x3C; a low-byte read clears RXRDY. A second byte arriving unread sets OVR.
- Inject a frame with stop bit 0 → FERR=1, RXRDY unchanged; a 0.3×BAUD_DIV low glitch → no state change.
